// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // Register x0 is hardwired to zero; writes to it are discarded.
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  // One pending writeback: destination register and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO. DEPTH must be a power of two so the pointers
// wrap naturally. The caller guarantees no push when full without a pop
// in the same cycle, and no pop when empty.
module wb_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage carries no reset: only entries counted as valid are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the in-order
// pipeline (port A, priority, no backpressure) and long-latency units
// (port B, valid/ready, buffered). Also tracks registers with an
// outstanding B-side write and requests pipeline bubbles when B starves.
//
// Handshake: a B transfer happens on a rising clk edge where b_valid and
// b_ready are both high; b_ready never depends on b_valid, and b_valid
// may be raised or held freely by the producer.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH    = REG_DATA_W,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          a_valid,
  input  logic [ADDRESS_WIDTH-1:0]      a_addr,
  input  logic [DATA_WIDTH-1:0]         a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [ADDRESS_WIDTH-1:0]      b_addr,
  input  logic [DATA_WIDTH-1:0]         b_data,
  input  logic                          iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]      iss_addr,
  output logic                          we,
  output logic [ADDRESS_WIDTH-1:0]      waddr,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [2**ADDRESS_WIDTH-1:0]   busy_mask,
  output logic                          stall_req,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t                    b_req;
  wb_req_t                    head;
  logic                       a_req;
  logic                       pop;
  logic                       push;
  logic                       full;
  logic                       empty;
  logic                       ready_q;
  logic [CW-1:0]              count_d;
  logic [SW-1:0]              starve_q;
  logic [SW-1:0]              starve_d;
  logic [2**ADDRESS_WIDTH-1:0] busy_d;

  // A write to x0 is no request at all, so B may drain in that cycle.
  assign a_req = a_valid && (a_addr != REG_X0);
  assign pop   = !a_req && !empty;

  // Accept while not full, or when full but the head leaves this cycle.
  assign b_ready = ready_q && (!full || pop);
  // x0 results complete the handshake but are never buffered.
  assign push    = b_valid && b_ready && (b_addr != REG_X0);

  assign b_req.addr = b_addr;
  assign b_req.data = b_data;

  wb_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wb_req_t))
  ) u_b_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (b_req),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Write-port mux: A first, else FIFO head, else idle with zeroed fields.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (a_req) begin
      we    = 1'b1;
      waddr = a_addr;
      wdata = a_data;
    end else if (!empty) begin
      we    = 1'b1;
      waddr = head.addr;
      wdata = head.data;
    end
  end

  // Next busy mask: clear on B writeback, then set on issue so set wins.
  always_comb begin
    busy_d = busy_mask;
    if (pop) busy_d[head.addr] = 1'b0;
    if (iss_valid && (iss_addr != REG_X0)) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Next starvation count: a non-empty FIFO that is not popping is blocked by A.
  always_comb begin
    if (pop || empty) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  assign count_d = fifo_count + CW'(push) - CW'(pop);

  // b_ready stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Hazard-tracking, starvation counter and the registered stall request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
      starve_q  <= '0;
      stall_req <= 1'b0;
    end else begin
      busy_mask <= busy_d;
      starve_q  <= starve_d;
      stall_req <= (starve_d >= SW'(STARVE_LIMIT)) || (count_d == CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against
// a queue-based behavioural model of the arbiter.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic                clk;
  logic                rst_n;
  logic                a_valid;
  logic [AW-1:0]       a_addr;
  logic [DW-1:0]       a_data;
  logic                b_valid;
  logic                b_ready;
  logic [AW-1:0]       b_addr;
  logic [DW-1:0]       b_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [DW-1:0]       wdata;
  logic [NUM_REGS-1:0] busy_mask;
  logic                stall_req;
  logic [1:0]          fifo_count;

  regfile_wb_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy_mask  (busy_mask),
    .stall_req  (stall_req),
    .fifo_count (fifo_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  wb_req_t             exp_q[$];   // pending B writebacks, oldest first
  logic [NUM_REGS-1:0] m_busy;
  int                  m_starve;
  bit                  m_ready_en;

  task automatic m_reset();
    exp_q.delete();
    m_busy     = '0;
    m_starve   = 0;
    m_ready_en = 1'b0;
  endtask

  function automatic bit m_a_req();
    return a_valid && (a_addr != REG_X0);
  endfunction

  function automatic bit m_pop();
    return !m_a_req() && (exp_q.size() > 0);
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic m_step();
    bit pop, brdy, push;
    pop  = m_pop();
    brdy = m_ready_en && ((exp_q.size() < DEPTH) || pop);
    push = b_valid && brdy && (b_addr != REG_X0);
    if (pop || exp_q.size() == 0) m_starve = 0;
    else if (m_starve < LIMIT)    m_starve = m_starve + 1;
    if (pop) begin
      m_busy[exp_q[0].addr] = 1'b0;
      void'(exp_q.pop_front());
    end
    if (iss_valid && iss_addr != REG_X0) m_busy[iss_addr] = 1'b1;
    if (push) exp_q.push_back('{addr: b_addr, data: b_data});
    m_ready_en = 1'b1;
  endtask

  // ---------------- compare process ----------------
  task automatic compare();
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_rdy;
    e_we   = 1'b0;
    e_addr = '0;
    e_data = '0;
    if (m_a_req()) begin
      e_we = 1'b1; e_addr = a_addr; e_data = a_data;
    end else if (exp_q.size() > 0) begin
      e_we = 1'b1; e_addr = exp_q[0].addr; e_data = exp_q[0].data;
    end
    e_rdy = m_ready_en && ((exp_q.size() < DEPTH) || m_pop());
    chk("we", we, e_we);
    chk("waddr", waddr, e_addr);
    chk("wdata", wdata, e_data);
    chk("b_ready", b_ready, e_rdy);
    chk("busy_mask", busy_mask, m_busy);
    chk("fifo_count", fifo_count, exp_q.size());
    chk("stall_req", stall_req, (m_starve >= LIMIT) || (exp_q.size() == DEPTH));
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      compare();
      @(posedge clk);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(bit av, logic [AW-1:0] aa, logic [DW-1:0] ad,
                        bit bv, logic [AW-1:0] ba, logic [DW-1:0] bd,
                        bit iv, logic [AW-1:0] ia);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    iss_valid = iv; iss_addr = ia;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset release then idle.
    tick(3);
    #1;
    chk("rst_we", we, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_busy", busy_mask, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_stall", stall_req, 0);

    // Issue r5, later B result for r5 written one cycle after handshake.
    set_in(0, 0, 0, 0, 0, 0, 1, 5);
    tick();
    idle();
    #1 chk("iss_busy5", busy_mask[5], 1);
    tick(3);
    set_in(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    #1 chk("b_no_bypass_we", we, 0);
    tick();
    idle();
    #1;
    chk("b_wr_we", we, 1);
    chk("b_wr_waddr", waddr, 5);
    chk("b_wr_wdata", wdata, 32'hDEADBEEF);
    tick();
    #1 chk("busy5_cleared", busy_mask[5], 0);

    // A holds the port; B entry starves until stall_req.
    set_in(1, 1, 32'h11, 1, 7, 32'h77, 0, 0);
    #1 chk("a_wins_waddr", waddr, 1);
    tick();
    set_in(1, 1, 32'h11, 0, 0, 0, 0, 0);
    tick(7);
    #1 chk("stall_before_limit", stall_req, 0);
    tick();
    #1 chk("stall_at_limit", stall_req, 1);
    idle();
    #1;
    chk("starved_waddr", waddr, 7);
    chk("starved_wdata", wdata, 32'h77);
    tick();
    #1 chk("stall_cleared", stall_req, 0);

    // Fill FIFO while A busy, then push and pop on the same edge.
    set_in(1, 1, 32'h11, 1, 10, 32'hA, 0, 0);
    tick();
    set_in(1, 1, 32'h11, 1, 11, 32'hB, 0, 0);
    tick();
    #1;
    chk("full_count", fifo_count, 2);
    chk("full_b_ready", b_ready, 0);
    chk("full_stall", stall_req, 1);
    set_in(0, 0, 0, 1, 12, 32'hC, 0, 0);
    #1;
    chk("full_pop_b_ready", b_ready, 1);
    chk("full_pop_waddr", waddr, 10);
    tick();
    #1 chk("pushpop_count", fifo_count, 2);
    idle();
    tick(2);
    #1 chk("drained_count", fifo_count, 0);

    // a_addr==0 lets the FIFO drain; b_addr==0 is accepted and dropped.
    set_in(0, 0, 0, 1, 13, 32'hD, 0, 0);
    tick();
    set_in(1, 0, 32'h55, 0, 0, 0, 0, 0);
    #1;
    chk("x0_a_waddr", waddr, 13);
    chk("x0_a_wdata", wdata, 32'hD);
    tick();
    set_in(0, 0, 0, 1, 0, 32'hBAD, 0, 0);
    #1 chk("x0_b_ready", b_ready, 1);
    tick();
    idle();
    #1;
    chk("x0_b_count", fifo_count, 0);
    chk("x0_b_we", we, 0);

    // Asynchronous reset with two entries and busy bits 3 and 9.
    set_in(0, 0, 0, 0, 0, 0, 1, 3);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    set_in(1, 1, 32'h11, 1, 3, 32'h3, 0, 0);
    tick();
    set_in(1, 1, 32'h11, 1, 9, 32'h9, 0, 0);
    tick();
    #1;
    chk("pre_rst_count", fifo_count, 2);
    chk("pre_rst_busy", busy_mask, 32'h0000_0208);
    idle();
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", we, 0);
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_busy", busy_mask, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    #1;
    chk("post_rst_we", we, 0);
    chk("post_rst_count", fifo_count, 0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 4, AW'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 9) < 5, AW'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 9) < 3, AW'($urandom_range(0, 31)));
      tick();
    end
    idle();
    tick(4);
    #1 chk("final_count", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
